// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and size helpers for the LSU
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Only the two low address bits can make a byte/half/word access misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of right-justified load data
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = acc;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & acc[7]}}, acc[7:0]};
            SZ_HALF: rdata = {{16{sign_ext & acc[15]}}, acc[15:0]};
            default: rdata = acc;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// rtl/lsu_byte_sequencer.sv - plays one load/store out over a byte-wide memory port, MSB first
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          sgn_q, sgn_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   acc_q, acc_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic [2:0]    nbytes;
    logic [2:0]    req_nbytes;
    logic          req_err;
    logic          last_byte;
    logic [1:0]    idx_nxt;
    logic [31:0]   acc_shift;
    logic [31:0]   ext_rdata;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        return w[8*k +: 8];
    endfunction

    assign nbytes     = size_nbytes(size_q);
    assign req_nbytes = size_nbytes(req_size);
    assign req_err    = (req_size == SZ_ILL) || is_misaligned(req_size, req_addr[1:0]);
    assign last_byte  = ({1'b0, idx_q} == (nbytes - 3'd1));
    assign idx_nxt    = idx_q + 2'd1;
    assign acc_shift  = {acc_q[23:0], mem_rdata};

    // Extension sees the accumulator including the byte arriving this cycle,
    // so the response can be registered on the same edge as the last byte.
    lsu_extend u_extend (
        .acc      (acc_shift),
        .size     (size_q),
        .sign_ext (sgn_q),
        .rdata    (ext_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    idx_d   = 2'd0;
                    acc_d   = 32'h0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = XFER;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = pick_byte(req_wdata, 2'(req_nbytes - 3'd1));
                    end
                end
            end
            XFER: begin
                if (!we_q) begin
                    acc_d = acc_shift;
                end
                if (last_byte) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_q ? 32'h0 : ext_rdata;
                end else begin
                    idx_d       = idx_nxt;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = addr_q + AW'(idx_nxt);
                    mem_wdata_d = pick_byte(wdata_q, 2'(nbytes - 3'd2) - idx_q);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            sgn_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            idx_q        <= 2'd0;
            acc_q        <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb/tb_lsu_byte_sequencer.sv - directed self-checking bench for lsu_byte_sequencer
module tb_lsu_byte_sequencer;
    import lsu_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0]    mem [0:511];
    logic          preload = 1'b1;
    int            en_count = 0;
    logic [AW-1:0] log_addr[$];
    logic [7:0]    log_wdata[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.AW(AW), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 4; i++) mem[i] <= 8'hA0 + 8'(i);
            mem[9'h010] <= 8'h8C;
            mem[9'h1FE] <= 8'h80;
            mem[9'h1FF] <= 8'h01;
        end else if (mem_en) begin
            en_count++;
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  {31'b0, req_ready},  32'h1);
        chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'h0);
        chk({tag, "_rdata"},  resp_rdata,          32'h0);
        chk({tag, "_rerr"},   {31'b0, resp_err},   32'h0);
        chk({tag, "_men"},    {31'b0, mem_en},     32'h0);
        chk({tag, "_mwe"},    {31'b0, mem_we},     32'h0);
        chk({tag, "_maddr"},  {23'b0, mem_addr},   32'h0);
        chk({tag, "_mwdata"}, {24'b0, mem_wdata},  32'h0);
    endtask

    // Issues one request from IDLE; lat counts edges from accept to the resp_valid cycle.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW-1:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int log0);
        int guard;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk("accept_wait", {31'b0, req_ready}, 32'h1);
        log0 = log_addr.size();
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("resp_seen", {31'b0, resp_valid}, 32'h1);
        rdata = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
        chk("resp_pulse", {31'b0, resp_valid}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          l0;
        int          e0;
        logic [31:0] rd;
        logic        er;
        logic [31:0] w;
        logic        err_we   [3];
        logic [1:0]  err_size [3];
        logic [8:0]  err_addr [3];

        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        e0 = en_count;
        do_req(1'b0, SZ_BYTE, 1'b1, 9'h010, 32'h0, lat, rd, er, l0);
        chk("lb_s_lat",   lat, 2);
        chk("lb_s_rdata", rd, 32'hFFFFFF8C);
        chk("lb_s_err",   {31'b0, er}, 32'h0);
        chk("lb_s_ncyc",  en_count - e0, 1);
        chk("lb_s_addr",  {23'b0, log_addr[l0]}, 32'h010);

        do_req(1'b0, SZ_BYTE, 1'b0, 9'h010, 32'h0, lat, rd, er, l0);
        chk("lb_u_lat",   lat, 2);
        chk("lb_u_rdata", rd, 32'h0000008C);

        do_req(1'b1, SZ_WORD, 1'b0, 9'h020, 32'hDEADBEEF, lat, rd, er, l0);
        chk("sw_lat",   lat, 5);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err",   {31'b0, er}, 32'h0);
        chk("sw_nbyte", log_addr.size() - l0, 4);
        w = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            chk("sw_addr",  {23'b0, log_addr[l0 + i]}, 32'h020 + i);
            chk("sw_wdata", {24'b0, log_wdata[l0 + i]}, {24'b0, w[31 - 8*i -: 8]});
        end

        do_req(1'b0, SZ_WORD, 1'b1, 9'h020, 32'h0, lat, rd, er, l0);
        chk("lw_lat",   lat, 5);
        chk("lw_rdata", rd, 32'hDEADBEEF);

        do_req(1'b0, SZ_HALF, 1'b1, 9'h1FE, 32'h0, lat, rd, er, l0);
        chk("lh_lat",   lat, 3);
        chk("lh_rdata", rd, 32'hFFFF8001);
        chk("lh_nbyte", log_addr.size() - l0, 2);
        chk("lh_addr0", {23'b0, log_addr[l0]}, 32'h1FE);
        chk("lh_addr1", {23'b0, log_addr[l0 + 1]}, 32'h1FF);

        err_we[0] = 1'b0; err_size[0] = SZ_WORD; err_addr[0] = 9'h022;
        err_we[1] = 1'b1; err_size[1] = SZ_HALF; err_addr[1] = 9'h031;
        err_we[2] = 1'b0; err_size[2] = SZ_ILL;  err_addr[2] = 9'h040;
        for (int i = 0; i < 3; i++) begin
            e0 = en_count;
            do_req(err_we[i], err_size[i], 1'b1, err_addr[i], 32'hCAFEF00D, lat, rd, er, l0);
            chk("err_flag",  {31'b0, er}, 32'h1);
            chk("err_rdata", rd, 32'h0);
            chk("err_lat",   lat, 1);
            chk("err_noen",  en_count - e0, 0);
        end

        req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 9'h080; req_wdata = 32'h01020304; req_valid = 1'b1;
        l0 = log_addr.size();
        @(posedge clk); #1;
        req_we = 1'b0; req_addr = 9'h020; req_wdata = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            chk("bp_stall", {31'b0, req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        chk("bp_ready", {31'b0, req_ready}, 32'h1);
        chk("bp_idle_noen", {31'b0, mem_en}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp_2nd_en",   {31'b0, mem_en}, 32'h1);
        chk("bp_2nd_addr", {23'b0, mem_addr}, 32'h020);
        chk("bp_2nd_we",   {31'b0, mem_we}, 32'h0);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_2nd_lat",   lat, 5);
        chk("bp_2nd_rdata", resp_rdata, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            chk("bp_1st_addr",  {23'b0, log_addr[l0 + i]}, 32'h080 + i);
            chk("bp_1st_wdata", {24'b0, log_wdata[l0 + i]}, 32'h1 + i);
            chk("bp_1st_mem",   {24'b0, mem[9'h080 + 9'(i)]}, 32'h1 + i);
        end
        @(posedge clk); #1;

        req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 9'h000; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_addr", {23'b0, mem_addr}, 32'h002);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_post_resp", {31'b0, resp_valid}, 32'h0);
            chk("rst_post_en",   {31'b0, mem_en}, 32'h0);
        end
        chk("rst_mem0", {24'b0, mem[0]}, 32'h11);
        chk("rst_mem1", {24'b0, mem[1]}, 32'h22);
        chk("rst_mem2", {24'b0, mem[2]}, 32'hA2);
        chk("rst_mem3", {24'b0, mem[3]}, 32'hA3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer that serves the MEM stage: it accepts one load or store request from the pipeline and plays it out, one byte per cycle, over a byte-wide memory port. Multi-byte values are big-endian, with the MSB at the lowest address. Loads are returned sign- or zero-extended; misaligned or illegal-size requests are rejected with an error and no memory access. The pipeline stalls on `req_ready` while a transfer is in flight.

## Interface
Parameters:
- `AW`, 9: byte address width (512-byte space).
- `DW`, 32: pipeline data width; fixed at 32.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_signed` input 1: sign-extend loads of byte and halfword size.
- `req_addr` input AW: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: misaligned or illegal size, valid with `resp_valid`.
- `mem_en` output 1: byte access this cycle.
- `mem_we` output 1: byte write this cycle; qualified by `mem_en`.
- `mem_addr` output AW: byte address.
- `mem_wdata` output 8: write byte.
- `mem_rdata` input 8: read byte; combinational from `mem_addr`, sampled at the clock edge.

## Operation
- The state machine has three states: `IDLE`, `XFER` and `RESP`.
- `req_ready` = (state == `IDLE`), decoded combinationally.
- **Accept.** A request is accepted at a rising edge when `req_valid && req_ready`. On accept, `we`, `size`, `signed`, `addr` and `wdata` are latched.
- **Byte count N.** 1 for byte, 2 for halfword, 4 for word.
- **Error check** at accept:
  - `size == 11` is an error.
  - Halfword with `addr[0] != 0` is an error.
  - Word with `addr[1:0] != 0` is an error.
  - On error: go to `RESP` with `resp_err = 1`. No `mem_en` is ever asserted for the request.
- **Otherwise** go to `XFER` with byte index `idx = 0`.
- **XFER**, byte `idx`:
  - `mem_en = 1` and `mem_we = we`.
  - `mem_addr = addr + idx`, mod 2^AW. Aligned requests never wrap.
  - `mem_wdata = wdata[8*(N-1-idx) +: 8]`, so the MSB goes first.
  - Loads: at each edge, `acc <= {acc[23:0], mem_rdata}`.
  - `idx` increments each cycle. After `idx == N-1`, go to `RESP`.
- **RESP** (one cycle): `resp_valid = 1`, then go to `IDLE`.
  - Load, no error: `resp_rdata` is `acc` extended to 32 bits.
  - Byte: `{{24{s & acc[7]}}, acc[7:0]}`.
  - Halfword: `{{16{s & acc[15]}}, acc[15:0]}`.
  - Word: `acc`, regardless of `signed`.
  - Here `s` is the latched `signed` bit.
  - Store or error: `resp_rdata = 0`.
- The response has no back-pressure; the pipeline always consumes `resp_valid`.
- `acc` is cleared on accept, so the unused upper bits of the accumulator are 0.
- **Reset mid-operation.** `rst_n` low forces `IDLE` immediately and aborts any transfer. Bytes already written stay written. No response is issued for the aborted request.

## Timing
- **Reset values:** `req_ready = 1`, `resp_valid = 0`, `resp_rdata = 0`, `resp_err = 0`, `mem_en = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`. Internal state is `IDLE`, with `idx` and `acc` both 0.
- **Accept at edge E:**
  - Memory bytes occupy cycles E+1 through E+N.
  - `resp_valid` is high in cycle E+N+1.
  - `req_ready` is high again in cycle E+N+2.
- **Error accept at edge E:** `resp_valid` and `resp_err` are high in cycle E+1, and `req_ready` is high in cycle E+2.
- **Throughput:** N+2 cycles per good request, 2 cycles per error.
- Memory outputs are registered or decoded from registered state only. There is no combinational path from `req_*` to `mem_*`.
- `req_*` inputs are ignored while `req_ready = 0`, including any `req_valid` asserted during `RESP`.

## Structure
- **Shared package `lsu_pkg`:**
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_ILL`.
  - State enum `IDLE` / `XFER` / `RESP`.
  - Function `size_nbytes(size)`.
  - Function `is_misaligned(size, addr)`.
  - The same size encodings are used by the word-wide data memory, so both share this package.
- **Sub-module `lsu_extend`:** combinational sign/zero extender. Inputs are `acc[31:0]`, `size` and `signed`; output is `rdata[31:0]`. It is reused by any future word-wide load path.
- Everything else lives in `lsu_byte_sequencer`: the FSM, `idx`, `acc` and the write-byte selection.

## Test plan
- **Signed-byte load.** Memory[0x010] = 0x8C; load byte, signed, addr 0x010.
  - Expect one `mem_en` cycle at address 0x010.
  - Expect `resp_rdata = 0xFFFFFF8C` and `resp_err = 0`, with `resp_valid` 2 cycles after accept.
  - Repeat unsigned: expect `0x0000008C`.
- **Word store then load.** Store word 0xDEADBEEF at addr 0x020.
  - Expect `mem_wdata` sequence DE, AD, BE, EF at addresses 0x020 through 0x023.
  - Then load word from 0x020: expect `resp_rdata = 0xDEADBEEF`, with `resp_valid` 5 cycles after accept.
- **Halfword load, signed.** Memory[0x1FE..0x1FF] = 0x80, 0x01; load halfword, signed, addr 0x1FE.
  - Expect `resp_rdata = 0xFFFF8001`.
  - Expect addresses 0x1FE and 0x1FF only, with no wrap.
- **Errors.**
  - Word load at 0x022, halfword store at 0x031, and `size = 11` at 0x040 each give `resp_err = 1` and `resp_rdata = 0` one cycle after accept.
  - In every case `mem_en` stays 0 throughout.
- **Back-pressure.** Hold `req_valid` high with a second request during the first word transfer.
  - Expect `req_ready = 0` for cycles E+1 through E+5.
  - Expect the second request to be accepted only at the first edge after `IDLE` is re-entered, and to complete correctly.
- **Reset mid-store.** Assert `rst_n = 0` after 2 bytes of a word store of 0x11223344 at 0x000.
  - Expect all outputs at their reset values immediately, and no `resp_valid`.
  - Expect memory[0x000..0x001] = 0x11, 0x22, with memory[0x002..0x003] unchanged.
